// File: rtl/spi_sensor_responder.sv
// SPI slave emulating the image sensor register interface: 16-bit frames of
// {ctrl, addr[6:0], data[7:0]}, pins oversampled by sys_clk, 128 x 8 register file.
module spi_sensor_responder #(
    parameter int                ADDR_W      = 7,
    parameter int                DATA_W      = 8,
    parameter logic [DATA_W-1:0] CHIP_ID     = 8'hA5,
    parameter int                SYNC_STAGES = 2
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              SPI_EN,
    input  logic              SPI_Clk,
    input  logic              SPI_IN,
    output logic              SPI_OUT,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_strobe,
    output logic              frame_err,
    output logic              busy,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int HDR_W   = 1 + ADDR_W;
    localparam int FRAME_W = HDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int SH_W    = ((DATA_W > HDR_W) ? DATA_W : HDR_W) - 1;
    localparam int DEPTH   = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, HEADER, DATA, WAIT_EN_LOW} state_t;

    logic [SYNC_STAGES-1:0] en_sync_q, clk_sync_q, din_sync_q;
    logic                   en_s, clk_s, din_s;
    logic                   en_prev_q, sclk_prev_q;
    logic                   en_rise, en_fall, sclk_rise, sclk_fall;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [SH_W-1:0]        shift_in_q, shift_in_d;
    logic                   ctrl_q, ctrl_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      shift_out_q, shift_out_d;
    logic                   spi_out_q, spi_out_d;
    logic                   wr_strobe_q, wr_strobe_d;
    logic                   rd_strobe_q, rd_strobe_d;
    logic                   frame_err_q, frame_err_d;
    logic [ADDR_W-1:0]      wr_addr_q;
    logic [DATA_W-1:0]      wr_data_q;
    logic                   busy_q;
    logic [DATA_W-1:0]      dbg_data_q;
    logic                   mem_we;
    logic [DATA_W-1:0]      mem_q [DEPTH];

    logic [ADDR_W-1:0]      hdr_addr;
    logic [DATA_W-1:0]      hdr_rdata;
    logic [DATA_W-1:0]      frame_data;

    assign en_s  = en_sync_q[SYNC_STAGES-1];
    assign clk_s = clk_sync_q[SYNC_STAGES-1];
    assign din_s = din_sync_q[SYNC_STAGES-1];

    assign en_rise   =  en_s  & ~en_prev_q;
    assign en_fall   = ~en_s  &  en_prev_q;
    assign sclk_rise =  clk_s & ~sclk_prev_q;
    assign sclk_fall = ~clk_s &  sclk_prev_q;

    // Address and data as they stand once the bit currently on din_s is shifted in.
    assign hdr_addr   = {shift_in_q[ADDR_W-2:0], din_s};
    assign hdr_rdata  = (hdr_addr == '0) ? CHIP_ID : mem_q[hdr_addr];
    assign frame_data = {shift_in_q[DATA_W-2:0], din_s};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_in_d  = shift_in_q;
        ctrl_d      = ctrl_q;
        addr_d      = addr_q;
        shift_out_d = shift_out_q;
        spi_out_d   = spi_out_q;
        wr_strobe_d = 1'b0;
        rd_strobe_d = 1'b0;
        frame_err_d = 1'b0;
        mem_we      = 1'b0;

        case (state_q)
            IDLE: begin
                if (en_rise) begin
                    state_d    = HEADER;
                    bit_cnt_d  = '0;
                    shift_in_d = '0;
                end
            end
            HEADER: begin
                if (en_fall) begin
                    state_d     = IDLE;
                    spi_out_d   = 1'b0;
                    frame_err_d = 1'b1;
                end else if (sclk_rise) begin
                    shift_in_d = {shift_in_q[SH_W-2:0], din_s};
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    if (bit_cnt_d == CNT_W'(HDR_W)) begin
                        ctrl_d  = shift_in_q[ADDR_W-1];
                        addr_d  = hdr_addr;
                        state_d = DATA;
                        if (!shift_in_q[ADDR_W-1]) begin
                            shift_out_d = hdr_rdata;
                        end
                    end
                end
            end
            DATA: begin
                if (en_fall) begin
                    state_d     = IDLE;
                    spi_out_d   = 1'b0;
                    frame_err_d = 1'b1;
                end else begin
                    if (sclk_rise) begin
                        if (ctrl_q) begin
                            shift_in_d = {shift_in_q[SH_W-2:0], din_s};
                        end
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_d == CNT_W'(FRAME_W)) begin
                            state_d = WAIT_EN_LOW;
                            if (ctrl_q) begin
                                wr_strobe_d = 1'b1;
                                mem_we      = (addr_q != '0);
                            end else begin
                                rd_strobe_d = 1'b1;
                            end
                        end
                    end
                    if (sclk_fall && !ctrl_q) begin
                        spi_out_d   = shift_out_q[DATA_W-1];
                        shift_out_d = shift_out_q << 1;
                    end
                end
            end
            WAIT_EN_LOW: begin
                if (en_fall) begin
                    state_d   = IDLE;
                    spi_out_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Synchronizers and frame shift registers carry no reset; every frame reloads them.
    always_ff @(posedge sys_clk) begin
        en_sync_q   <= (en_sync_q << 1)  | SYNC_STAGES'(SPI_EN);
        clk_sync_q  <= (clk_sync_q << 1) | SYNC_STAGES'(SPI_Clk);
        din_sync_q  <= (din_sync_q << 1) | SYNC_STAGES'(SPI_IN);
        shift_in_q  <= shift_in_d;
        ctrl_q      <= ctrl_d;
        addr_q      <= addr_d;
        shift_out_q <= shift_out_d;
    end

    // en_prev resets high so an enable still asserted after reset is not taken as a new frame.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            en_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b0;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            spi_out_q   <= 1'b0;
            wr_strobe_q <= 1'b0;
            rd_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
            dbg_data_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            en_prev_q   <= en_s;
            sclk_prev_q <= clk_s;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            spi_out_q   <= spi_out_d;
            wr_strobe_q <= wr_strobe_d;
            rd_strobe_q <= rd_strobe_d;
            frame_err_q <= frame_err_d;
            busy_q      <= (state_d != IDLE);
            dbg_data_q  <= (dbg_addr == '0) ? CHIP_ID : mem_q[dbg_addr];
            if (wr_strobe_d) begin
                wr_addr_q <= addr_q;
                wr_data_q <= frame_data;
            end
            if (mem_we) begin
                mem_q[addr_q] <= frame_data;
            end
        end
    end

    assign SPI_OUT   = spi_out_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign rd_strobe = rd_strobe_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;
    assign dbg_data  = dbg_data_q;

endmodule

// File: tb/tb_spi_sensor_responder.sv
// Directed bench for spi_sensor_responder: bit-banged SPI frames with hand-computed results.
module tb_spi_sensor_responder;

    logic       sys_clk = 1'b0;
    logic       reset;
    logic       SPI_EN, SPI_Clk, SPI_IN;
    logic       SPI_OUT;
    logic       wr_strobe, rd_strobe, frame_err, busy;
    logic [6:0] wr_addr, dbg_addr;
    logic [7:0] wr_data, dbg_data;

    int checks = 0, failures = 0;
    int wr_cnt = 0, rd_cnt = 0, err_cnt = 0, overlap_cnt = 0;
    logic busy_mid;

    spi_sensor_responder dut (
        .sys_clk  (sys_clk),
        .reset    (reset),
        .SPI_EN   (SPI_EN),
        .SPI_Clk  (SPI_Clk),
        .SPI_IN   (SPI_IN),
        .SPI_OUT  (SPI_OUT),
        .wr_strobe(wr_strobe),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_strobe(rd_strobe),
        .frame_err(frame_err),
        .busy     (busy),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (wr_strobe) wr_cnt++;
        if (rd_strobe) rd_cnt++;
        if (frame_err) err_cnt++;
        if ((int'(wr_strobe) + int'(rd_strobe) + int'(frame_err)) > 1) overlap_cnt++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // One SPI frame, SPI_Clk half-period of 4 sys_clk; captures SPI_OUT after falls 8..15.
    task automatic spi_xfer(input logic [15:0] word, input int nrise, input int gap,
                            input bit hold_en, output logic [7:0] rd);
        rd = '0;
        SPI_EN = 1'b1;
        cyc(4);
        busy_mid = busy;
        for (int i = 0; i < nrise; i++) begin
            SPI_IN = (i < 16) ? word[15-i] : 1'b0;
            cyc(4);
            SPI_Clk = 1'b1;
            cyc(4);
            SPI_Clk = 1'b0;
            cyc(4);
            if (i >= 7 && i <= 14) rd[14-i] = SPI_OUT;
        end
        if (!hold_en) begin
            cyc(4);
            SPI_EN = 1'b0;
            SPI_IN = 1'b0;
            cyc(gap);
        end
    endtask

    task automatic dbg_rd(input logic [6:0] a, output logic [7:0] d);
        dbg_addr = a;
        cyc(2);
        d = dbg_data;
    endtask

    initial begin
        logic [7:0]  rd, dd;
        logic [15:0] w;
        logic [6:0]  a;
        int w0, r0, e0;

        reset = 1'b1; SPI_EN = 1'b0; SPI_Clk = 1'b0; SPI_IN = 1'b0; dbg_addr = '0;
        cyc(5);
        check_eq("rst_spi_out",  SPI_OUT,   0);
        check_eq("rst_busy",     busy,      0);
        check_eq("rst_wr_strb",  wr_strobe, 0);
        check_eq("rst_rd_strb",  rd_strobe, 0);
        check_eq("rst_ferr",     frame_err, 0);
        check_eq("rst_wr_addr",  wr_addr,   0);
        check_eq("rst_wr_data",  wr_data,   0);
        check_eq("rst_dbg_data", dbg_data,  0);
        reset = 1'b0;
        cyc(3);
        check_eq("dbg_chip_id", dbg_data, 8'hA5);

        // Write 0x3A <= 0x5C, then read it back
        w0 = wr_cnt; e0 = err_cnt;
        spi_xfer(16'hBA5C, 16, 6, 1'b0, rd);
        check_eq("w3a_strobes", wr_cnt - w0, 1);
        check_eq("w3a_wr_addr", wr_addr, 7'h3A);
        check_eq("w3a_wr_data", wr_data, 8'h5C);
        check_eq("w3a_no_err",  err_cnt - e0, 0);
        check_eq("w3a_busy_mid", busy_mid, 1);
        check_eq("w3a_busy_end", busy, 0);
        dbg_rd(7'h3A, dd);
        check_eq("w3a_dbg", dd, 8'h5C);
        r0 = rd_cnt;
        spi_xfer(16'h3A00, 16, 6, 1'b0, rd);
        check_eq("r3a_data",    rd, 8'h5C);
        check_eq("r3a_strobes", rd_cnt - r0, 1);
        check_eq("r3a_out_idle", SPI_OUT, 0);

        // Address 0 is the read-only chip ID
        spi_xfer(16'h0000, 16, 6, 1'b0, rd);
        check_eq("r00_chip_id", rd, 8'hA5);
        w0 = wr_cnt;
        spi_xfer(16'h80FF, 16, 6, 1'b0, rd);
        check_eq("w00_strobes", wr_cnt - w0, 1);
        check_eq("w00_wr_addr", wr_addr, 7'h00);
        check_eq("w00_wr_data", wr_data, 8'hFF);
        spi_xfer(16'h0000, 16, 6, 1'b0, rd);
        check_eq("r00_after_w", rd, 8'hA5);
        dbg_rd(7'h00, dd);
        check_eq("dbg00_after_w", dd, 8'hA5);

        // Abort after 11 rising edges
        w0 = wr_cnt; e0 = err_cnt;
        spi_xfer(16'h9177, 11, 6, 1'b0, rd);
        check_eq("abort_ferr",   err_cnt - e0, 1);
        check_eq("abort_no_wr",  wr_cnt - w0, 0);
        dbg_rd(7'h11, dd);
        check_eq("abort_reg11",  dd, 8'h00);
        check_eq("abort_out",    SPI_OUT, 0);

        // 20 clock pulses: the extra 4 are ignored
        w0 = wr_cnt; e0 = err_cnt;
        spi_xfer(16'h8123, 20, 6, 1'b0, rd);
        check_eq("long_strobes", wr_cnt - w0, 1);
        check_eq("long_wr_data", wr_data, 8'h23);
        check_eq("long_no_err",  err_cnt - e0, 0);
        check_eq("long_busy",    busy, 0);
        dbg_rd(7'h01, dd);
        check_eq("long_dbg01",   dd, 8'h23);
        spi_xfer(16'h0100, 16, 6, 1'b0, rd);
        check_eq("long_rd01",    rd, 8'h23);

        // Reset after 9 bits of a write
        w0 = wr_cnt; e0 = err_cnt; r0 = rd_cnt;
        spi_xfer(16'h8C44, 9, 0, 1'b1, rd);
        reset = 1'b1;
        cyc(2);
        SPI_EN = 1'b0;
        SPI_IN = 1'b0;
        cyc(4);
        reset = 1'b0;
        cyc(4);
        check_eq("rstmid_no_wr",   wr_cnt - w0, 0);
        check_eq("rstmid_no_rd",   rd_cnt - r0, 0);
        check_eq("rstmid_no_err",  err_cnt - e0, 0);
        check_eq("rstmid_out",     SPI_OUT, 0);
        check_eq("rstmid_busy",    busy, 0);
        dbg_rd(7'h0C, dd);
        check_eq("rstmid_reg0c",   dd, 8'h00);
        dbg_rd(7'h3A, dd);
        check_eq("rstmid_reg3a",   dd, 8'h00);
        w0 = wr_cnt;
        spi_xfer(16'h8C44, 16, 6, 1'b0, rd);
        check_eq("rstmid_rewr",    wr_cnt - w0, 1);
        dbg_rd(7'h0C, dd);
        check_eq("rstmid_reg0c_w", dd, 8'h44);

        // Back-to-back writes with a 3-cycle enable gap
        w0 = wr_cnt; e0 = err_cnt;
        for (int k = 0; k < 8; k++) begin
            a = 7'(8'h10 + k);
            w = {1'b1, a, 8'(8'h11 + k)};
            spi_xfer(w, 16, 3, 1'b0, rd);
        end
        cyc(4);
        check_eq("b2b_strobes", wr_cnt - w0, 8);
        check_eq("b2b_no_err",  err_cnt - e0, 0);
        check_eq("b2b_wr_addr", wr_addr, 7'h17);
        check_eq("b2b_wr_data", wr_data, 8'h18);
        for (int k = 0; k < 8; k++) begin
            a = 7'(8'h10 + k);
            w = {1'b0, a, 8'h00};
            spi_xfer(w, 16, 6, 1'b0, rd);
            check_eq($sformatf("b2b_spi_rd_%0h", a), rd, 8'(8'h11 + k));
            dbg_rd(a, dd);
            check_eq($sformatf("b2b_dbg_rd_%0h", a), dd, 8'(8'h11 + k));
        end

        check_eq("strobe_overlap", overlap_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_sensor_responder.md
Name: spi_sensor_responder

Overview:
- Synthesizable SPI slave that emulates the image sensor's register interface: 16-bit frames, 7-bit address, 8-bit data.
- Serves as the far end of the SPI write/read masters, for on-FPGA loopback and simulation of the imager bring-up sequence without the sensor attached.
- Oversamples the SPI pins with the system clock and holds a 128 x 8 register file.
- Exposes write/read event strobes and a debug read port.

Parameters:
- ADDR_W, 7, register address width (register file depth = 2^ADDR_W).
- DATA_W, 8, register data width.
- CHIP_ID, 8'hA5, read-only value at address 0.
- SYNC_STAGES, 2, synchronizer flops on SPI_EN, SPI_Clk and SPI_IN.

Ports:
- sys_clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- SPI_EN  input  1  frame enable from master, active high.
- SPI_Clk  input  1  serial clock from master, idle low.
- SPI_IN  input  1  master-to-slave data, MSB first.
- SPI_OUT  output  1  slave-to-master read data.
- wr_strobe  output  1  one-cycle pulse when a write commits.
- wr_addr  output  7  address of the last committed write.
- wr_data  output  8  data of the last committed write.
- rd_strobe  output  1  one-cycle pulse when a read frame completes.
- frame_err  output  1  one-cycle pulse on an aborted or malformed frame.
- busy  output  1  high while a frame is in progress (synchronized SPI_EN high).
- dbg_addr  input  7  debug read address.
- dbg_data  output  8  register[dbg_addr], registered, 1-cycle latency.

Behaviour:
- Frame format: bit15 = ctrl (1 write, 0 read), bits14:8 = addr, bits7:0 = data. Slave samples SPI_IN on SPI_Clk rising edge. For reads, the slave drives SPI_OUT after SPI_Clk falling edges.
- Synchronization: SPI_EN, SPI_Clk and SPI_IN each pass through SYNC_STAGES flops. One further register generates one-cycle pulses: sclk_rise, sclk_fall, en_rise, en_fall. Pin-to-action latency = SYNC_STAGES+1 sys_clk cycles. Master SPI_Clk half-period must be >= 3 sys_clk cycles.
- Reset values:
  - SPI_OUT, wr_strobe, rd_strobe, frame_err, busy = 0; wr_addr, wr_data = 0; dbg_data = 0.
  - All registers = 0, except address 0, which always reads CHIP_ID.
  - State = IDLE; bit_cnt = 0.
- Reset asserted mid-frame: frame is discarded, no strobes, register contents reset. The FSM stays IDLE until the next en_rise.
- FSM states: IDLE, HEADER, DATA, WAIT_EN_LOW.
  - IDLE: on en_rise, go to HEADER with bit_cnt = 0 and shift_in = 0.
  - HEADER: each sclk_rise shifts sync SPI_IN into shift_in and increments bit_cnt. When bit_cnt reaches 8:
    - latch ctrl and addr;
    - if read, load shift_out = (addr==0 ? CHIP_ID : reg[addr]);
    - go to DATA.
  - DATA:
    - Write frame: each sclk_rise shifts in data.
    - Read frame: each sclk_fall drives SPI_OUT = shift_out[7] and shifts shift_out left. The first fall, after the 8th rise, presents bit7. Incoming SPI_IN bits are ignored.
    - On the 16th sclk_rise, go to WAIT_EN_LOW. In the following cycle:
      - write: reg[addr] <= data unless addr==0; wr_strobe = 1, wr_addr/wr_data updated (also for addr 0, whose write is dropped);
      - read: rd_strobe = 1.
  - WAIT_EN_LOW: further SPI_Clk edges are ignored and SPI_OUT holds its last value. On en_fall, go to IDLE with SPI_OUT = 0.
- Abort: en_fall in HEADER or DATA (bit_cnt < 16) gives:
  - frame_err pulse next cycle;
  - no register update, no wr_strobe/rd_strobe;
  - SPI_OUT = 0, state = IDLE.
- sclk_rise coinciding with en_fall: the abort wins and the bit is discarded.
- en_rise while not IDLE (impossible when synchronized) is ignored.
- SPI_OUT is 0 whenever not in a read DATA/WAIT_EN_LOW phase. No tristate.
- Debug read port: dbg_data <= (dbg_addr==0 ? CHIP_ID : reg[dbg_addr]) every cycle. A same-cycle write commit is visible on the cycle after commit.
- Strobes never assert simultaneously. Back-to-back frames need SPI_EN low for >= 3 sys_clk cycles.

Test Plan:
- Write frame 0xBA5C (addr 0x3A, data 0x5C): wr_strobe one pulse, wr_addr=0x3A, wr_data=0x5C. dbg_addr=0x3A gives dbg_data=0x5C. Then read frame 0x3A00: SPI_OUT bits 0,1,0,1,1,1,0,0 on falls 8..15, rd_strobe one pulse.
- Read frame 0x0000: SPI_OUT serializes 0xA5. Write frame 0x80FF: wr_strobe pulses, but a following read of address 0 still returns 0xA5.
- Drop SPI_EN after 11 SPI_Clk rising edges of write 0x9177: frame_err one pulse, wr_strobe stays 0, reg[0x11] unchanged (0x00).
- Write 0x8123 with 20 SPI_Clk pulses: exactly one wr_strobe, reg[0x01]=0x23, extra edges ignored, busy falls after SPI_EN low.
- Assert reset after 9 bits of write 0x8C44: no strobe, reg[0x0C]=0x00, SPI_OUT=0. The next full write 0x8C44 commits normally.
- Back-to-back writes to 0x10..0x17 with data = addr+1, SPI_EN gap 3 cycles: 8 wr_strobes, all 8 read back correctly via SPI and the debug port.
